// File: rtl/expr_lane_pkg.sv
// expr_lane_pkg: shared opcode enum, widths and operand extension helper
package expr_lane_pkg;
  localparam int OP_W = 4;
  localparam int CNT_W = 16;
  typedef enum logic [OP_W-1:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_SHL,
    OP_SHR, OP_ASHR, OP_LT, OP_LE, OP_EQ, OP_NE, OP_LAND, OP_LOR
  } op_e;
  function automatic logic [31:0] sext_zext(input logic [31:0] val, input logic is_signed, input int w);
    logic [31:0] m;
    m = (32'h1 << w) - 32'h1;
    return (is_signed && val[w-1]) ? (val | ~m) : (val & m);
  endfunction
endpackage

// File: rtl/expr_lane_alu.sv
// expr_lane_alu: one combinational lane evaluating a W-bit op with Verilog width and sign rules
module expr_lane_alu import expr_lane_pkg::*; #(
  parameter int W = 6
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [OP_W-1:0] op,
  input  logic            is_signed,
  output logic [W-1:0]    y,
  output logic            ovf
);
  localparam int W2 = 2 * W;
  logic [W2-1:0] ax, bx, r;
  logic signed [W-1:0] sa, sb, asr;
  logic lt, eq, arith;
  // Arithmetic runs on 2W-bit extended operands so overflow shows up in the upper bits
  always_comb begin
    ax = W2'(sext_zext(32'(a), is_signed, W));
    bx = W2'(sext_zext(32'(b), is_signed, W));
    sa = $signed(a);
    sb = $signed(b);
    asr = sa >>> b;
    lt = is_signed ? (sa < sb) : (a < b);
    eq = a == b;
    arith = op_e'(op) inside {OP_ADD, OP_SUB, OP_MUL};
    r = op_e'(op) == OP_ADD ? ax + bx : op_e'(op) == OP_SUB ? ax - bx : ax * bx;
    ovf = arith && (is_signed ? !(&r[W2-1:W-1] || ~|r[W2-1:W-1]) : |r[W2-1:W]);
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_SHL:  y = a << b;
      OP_SHR:  y = a >> b;
      OP_ASHR: y = is_signed ? asr : a >> b;
      OP_LT:   y = W'(lt);
      OP_LE:   y = W'(lt || eq);
      OP_EQ:   y = W'(eq);
      OP_NE:   y = W'(!eq);
      OP_LAND: y = W'(|a && |b);
      OP_LOR:  y = W'(|a || |b);
      default: y = r[W-1:0];
    endcase
  end
endmodule

// File: rtl/expr_lane_pipe.sv
// expr_lane_pipe: LANES-wide expression evaluator behind a STAGES-deep valid/ready pipeline
// EXPR_LANE_PIPE_PARITY_EN adds out_par, the registered even parity of each lane result
module expr_lane_pipe import expr_lane_pkg::*; #(
  parameter int               LANES       = 4,
  parameter int               W           = 6,
  parameter logic [LANES-1:0] SIGNED_MASK = 4'b1010,
  parameter int               STAGES      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*W-1:0]    in_a,
  input  logic [LANES*W-1:0]    in_b,
  input  logic [LANES*OP_W-1:0] in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*W-1:0]    out_y,
  output logic [LANES-1:0]      out_ovf,
`ifdef EXPR_LANE_PIPE_PARITY_EN
  output logic [LANES-1:0]      out_par,
`endif
  output logic [CNT_W-1:0]      out_count
);
`ifdef EXPR_LANE_PIPE_PARITY_EN
  localparam int PW = LANES * W + 2 * LANES;
`else
  localparam int PW = LANES * W + LANES;
`endif
  logic [LANES*W-1:0] alu_y;
  logic [LANES-1:0] alu_ovf;
  logic [PW-1:0] in_p;
  logic [PW-1:0] p_q [STAGES];
  logic [PW-1:0] p_d [STAGES];
  logic [STAGES-1:0] v_q, v_d, adv;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    expr_lane_alu #(.W(W)) u_alu (
      .a(in_a[i*W +: W]),
      .b(in_b[i*W +: W]),
      .op(in_op[i*OP_W +: OP_W]),
      .is_signed(SIGNED_MASK[i]),
      .y(alu_y[i*W +: W]),
      .ovf(alu_ovf[i])
    );
  end
`ifdef EXPR_LANE_PIPE_PARITY_EN
  logic [LANES-1:0] alu_par;
  for (genvar i = 0; i < LANES; i++) begin : g_par
    assign alu_par[i] = ^alu_y[i*W +: W];
  end
  assign in_p = {alu_par, alu_ovf, alu_y};
  assign out_par = p_q[STAGES-1][LANES*W+LANES +: LANES];
`else
  assign in_p = {alu_ovf, alu_y};
`endif
  // Stage k advances when it or any later stage is empty, or the output beat is taken
  always_comb begin
    for (int k = 0; k < STAGES; k++) adv[k] = out_ready || !(&(v_q | STAGES'((1 << k) - 1)));
    v_d[0] = adv[0] ? in_valid : v_q[0];
    p_d[0] = (adv[0] && in_valid) ? in_p : p_q[0];
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = adv[k] ? v_q[k-1] : v_q[k];
      p_d[k] = (adv[k] && v_q[k-1]) ? p_q[k-1] : p_q[k];
    end
    cnt_d = cnt_q + CNT_W'(v_q[STAGES-1] && out_ready);
  end
  // Pipeline registers; reset drops every in-flight beat and clears the payload
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) p_q[k] <= '0;
    end else begin
      v_q <= v_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < STAGES; k++) p_q[k] <= p_d[k];
    end
  end
  assign in_ready = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign out_y = p_q[STAGES-1][LANES*W-1:0];
  assign out_ovf = p_q[STAGES-1][LANES*W +: LANES];
  assign out_count = cnt_q;
endmodule

// File: tb/tb_expr_lane_pipe.sv
// tb_expr_lane_pipe: directed and random checks of expr_lane_pipe against an integer reference model
module tb_expr_lane_pipe;
  localparam int LANES = 4;
  localparam int W = 6;
  localparam logic [3:0] SM = 4'b1010;
  typedef struct {
    logic [23:0] y;
    logic [3:0]  ovf;
    logic [3:0]  par;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [23:0] in_a = '0;
  logic [23:0] in_b = '0;
  logic [15:0] in_op = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [23:0] out_y;
  logic [3:0] out_ovf;
  logic [15:0] out_count;
`ifdef EXPR_LANE_PIPE_PARITY_EN
  logic [3:0] out_par;
`endif
  beat_t q[$];
  int checks = 0;
  int failures = 0;
  int delivered = 0;
  int accepted = 0;
  bit seen_nr = 1'b0;

  expr_lane_pipe #(.LANES(LANES), .W(W), .SIGNED_MASK(SM), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_ovf(out_ovf),
`ifdef EXPR_LANE_PIPE_PARITY_EN
    .out_par(out_par),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic beat_t model(input logic [23:0] a, input logic [23:0] b, input logic [15:0] op);
    beat_t r;
    r.y = '0;
    r.ovf = '0;
    r.par = '0;
    for (int i = 0; i < LANES; i++) begin
      int ua, ub, sa, sb, o, res;
      longint t;
      bit s;
      ua = int'(a[i*6 +: 6]);
      ub = int'(b[i*6 +: 6]);
      o = int'(op[i*4 +: 4]);
      s = SM[i];
      sa = (s && ua >= 32) ? ua - 64 : ua;
      sb = (s && ub >= 32) ? ub - 64 : ub;
      t = 0;
      res = 0;
      case (o)
        0: t = longint'(sa) + longint'(sb);
        1: t = longint'(sa) - longint'(sb);
        2: t = longint'(sa) * longint'(sb);
        3: res = ua & ub;
        4: res = ua | ub;
        5: res = ua ^ ub;
        6: res = ~(ua ^ ub) & 63;
        7: res = ub >= 6 ? 0 : (ua << ub) & 63;
        8: res = ub >= 6 ? 0 : ua >> ub;
        9: res = !s ? (ub >= 6 ? 0 : ua >> ub) : (ub >= 6 ? (sa < 0 ? 63 : 0) : (sa >>> ub) & 63);
        10: res = int'(sa < sb);
        11: res = int'(sa <= sb);
        12: res = int'(sa == sb);
        13: res = int'(sa != sb);
        14: res = int'(ua != 0 && ub != 0);
        default: res = int'(ua != 0 || ub != 0);
      endcase
      if (o < 3) begin
        res = int'(t & 64'd63);
        r.ovf[i] = s ? (t < -32 || t > 31) : (t < 0 || t > 63);
      end
      r.y[i*6 +: 6] = 6'(res);
      r.par[i] = ^r.y[i*6 +: 6];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    beat_t e;
    #1;
    if (in_valid && !in_ready) seen_nr = 1'b1;
    if (out_valid && out_ready) begin
      delivered++;
      chk("scoreboard_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("lane_y", 32'(out_y), 32'(e.y));
        chk("lane_ovf", 32'(out_ovf), 32'(e.ovf));
`ifdef EXPR_LANE_PIPE_PARITY_EN
        chk("lane_par", 32'(out_par), 32'(e.par));
`endif
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(in_a, in_b, in_op));
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic rand_inputs();
    in_a = 24'($urandom);
    in_b = 24'($urandom);
    in_op = 16'($urandom);
  endtask

  task automatic send_directed(input logic [23:0] a, input logic [23:0] b, input logic [15:0] op);
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("latency_cycle1_idle", 32'(out_valid), 32'd0);
    tick();
    chk("latency_cycle2_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [23:0] held;
    bit stall;
    int base;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef EXPR_LANE_PIPE_PARITY_EN
    chk("rst_out_par", 32'(out_par), 32'd0);
`endif
    send_directed({6'h30, 6'd7, 6'd31, 6'd3}, {6'd9, 6'd9, 6'd1, 6'd5}, {4'd9, 4'd2, 4'd0, 4'd1});
    chk("sub_unsigned_y0", 32'(out_y[5:0]), 32'd62);
    chk("sub_unsigned_ovf0", 32'(out_ovf[0]), 32'd1);
    chk("add_signed_y1", 32'(out_y[11:6]), 32'h20);
    chk("add_signed_ovf1", 32'(out_ovf[1]), 32'd1);
    chk("mul_unsigned_y2", 32'(out_y[17:12]), 32'd63);
    chk("mul_unsigned_ovf2", 32'(out_ovf[2]), 32'd0);
    chk("ashr_signed_big_y3", 32'(out_y[23:18]), 32'h3F);
    tick();
    send_directed({6'd0, 6'd7, 6'h3F, 6'h30}, {6'd0, 6'd7, 6'd0, 6'd2}, {4'd3, 4'd3, 4'd10, 4'd9});
    chk("ashr_unsigned_y0", 32'(out_y[5:0]), 32'h0C);
    chk("lt_signed_y1", 32'(out_y[11:6]), 32'd1);
    chk("cmp_no_ovf", 32'(out_ovf), 32'd0);
    tick();
    send_directed({6'd0, 6'd0, 6'd0, 6'd7}, {6'd0, 6'd0, 6'd0, 6'd0}, {4'd3, 4'd3, 4'd3, 4'd4});
    chk("or_y0", 32'(out_y[5:0]), 32'h07);
`ifdef EXPR_LANE_PIPE_PARITY_EN
    chk("parity_y0", 32'(out_par[0]), 32'd1);
`endif
    tick();
    do_reset();
    accepted = 0;
    seen_nr = 1'b0;
    rand_inputs();
    for (int c = 0; c < 30; c++) begin
      in_valid = accepted < 8;
      out_ready = !(c >= 3 && c <= 5);
      stall = !out_ready && out_valid;
      held = out_y;
      base = accepted;
      tick();
      if (accepted != base) rand_inputs();
      if (stall) begin
        chk("stall_valid_hold", 32'(out_valid), 32'd1);
        chk("stall_y_hold", 32'(out_y), 32'(held));
      end
    end
    chk("stream_in_ready_drop", 32'(seen_nr), 32'd1);
    chk("stream_all_accepted", 32'(accepted), 32'd8);
    chk("stream_drained", 32'(q.size()), 32'd0);
    chk("stream_count", 32'(out_count), 32'd8);
    out_ready = 1'b1;
    in_valid = 1'b1;
    rand_inputs();
    tick();
    rand_inputs();
    tick();
    chk("inflight_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    chk("midrst_out_y", 32'(out_y), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("postrst_no_beat", 32'(out_valid), 32'd0);
    end
    rand_inputs();
    send_directed(in_a, in_b, in_op);
    tick();
    chk("postrst_count", 32'(out_count), 32'd1);
    do_reset();
    base = delivered;
    for (int c = 0; c < 300; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      rand_inputs();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("random_drained", 32'(q.size()), 32'd0);
    chk("random_count", 32'(out_count), 32'(delivered - base));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
